multicycle_ctrl: RTL and testbench

Moore-style control FSM with Mealy handshake outputs for the multicycle CPU. Sequences one instruction at a time through fetch, decode, execute, memory and write-back. Drives the ALU operand selects (`aluX`, `aluY`), ALU operation, register-file, PC, IR and memory strobes. Sits beside the datapath and consumes only IR fields, the ALU `zero` flag and the memory `memReady` handshake.

---
 rtl/cpu_ctrl_pkg.sv | 78 +++++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/alu_op_decode.sv | 25 ++
 rtl/multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multicycle CPU: state encoding, opcode/funct
// values, ALU operand selects and ALU operation codes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_SH  = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_R     = 4'd6,
        S_WB_I     = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

    localparam logic [1:0] ALUX_RS = 2'd0;
    localparam logic [1:0] ALUX_RT = 2'd1;
    localparam logic [1:0] ALUX_PC = 2'd2;

    localparam logic [2:0] ALUY_RT    = 3'd0;
    localparam logic [2:0] ALUY_SHAMT = 3'd1;
    localparam logic [2:0] ALUY_IMM   = 3'd2;
    localparam logic [2:0] ALUY_FOUR  = 3'd3;
    localparam logic [2:0] ALUY_RS    = 3'd4;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] pc_src;
        logic [1:0] alu_x;
        logic [2:0] alu_y;
        alu_op_t    alu_op;
        logic       illegal_inst;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       memReady;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic       memToReg;
    logic       regDst;
    logic [1:0] pcSrc;
    logic [1:0] aluX;
    logic [2:0] aluY;
    logic [3:0] aluOp;
    logic       illegalInst;
    logic [3:0] stateOut;

    modport master (
        input  opcode, funct, zero, memReady,
        output memRead, memWrite, iOrD, irWrite, pcWrite, regWrite, memToReg,
               regDst, pcSrc, aluX, aluY, aluOp, illegalInst, stateOut
    );

    modport slave (
        output opcode, funct, zero, memReady,
        input  memRead, memWrite, iOrD, irWrite, pcWrite, regWrite, memToReg,
               regDst, pcSrc, aluX, aluY, aluOp, illegalInst, stateOut
    );
endinterface

// File: rtl/alu_op_decode.sv
// R-type funct decoder: ALU operation, shift classification and legality.
module alu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       is_shift,
    output logic       legal
);
    always_comb begin
        alu_op   = ALU_ADD;
        is_shift = 1'b0;
        legal    = 1'b1;
        case (funct)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            FN_SLL: begin alu_op = ALU_SLL; is_shift = 1'b1; end
            FN_SRL: begin alu_op = ALU_SRL; is_shift = 1'b1; end
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: Moore state sequencing with memReady/zero-gated
// handshake outputs in FETCH and BRANCH.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    state_t  state_reg;
    state_t  state_next;
    ctrl_t   ctl;
    alu_op_t dec_op;
    logic    dec_shift;
    logic    dec_legal;

    alu_op_decode u_dec (
        .funct    (bus.funct),
        .alu_op   (dec_op),
        .is_shift (dec_shift),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (bus.memReady) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (!dec_legal)     state_next = S_TRAP;
                        else if (dec_shift) state_next = S_EXEC_SH;
                        else                state_next = S_EXEC_R;
                    end
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_SH: state_next = S_WB_R;
            S_EXEC_I:            state_next = S_WB_I;
            S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: if (bus.memReady) state_next = S_WB_MEM;
            S_MEM_WR: if (bus.memReady) state_next = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ctl = '0;
        case (state_reg)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                ctl.alu_x    = ALUX_PC;
                ctl.alu_y    = ALUY_FOUR;
                ctl.alu_op   = ALU_ADD;
                ctl.ir_write = bus.memReady;
                ctl.pc_write = bus.memReady;
                ctl.pc_src   = PCSRC_ALU;
            end
            // Branch target (pc + offset) is computed here and lands in aluOut.
            S_DECODE: begin
                ctl.alu_x  = ALUX_PC;
                ctl.alu_y  = ALUY_IMM;
                ctl.alu_op = ALU_ADD;
            end
            S_EXEC_R: begin
                ctl.alu_x  = ALUX_RS;
                ctl.alu_y  = ALUY_RT;
                ctl.alu_op = dec_op;
            end
            S_EXEC_SH: begin
                ctl.alu_x  = ALUX_RT;
                ctl.alu_y  = ALUY_SHAMT;
                ctl.alu_op = dec_op;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctl.alu_x  = ALUX_RS;
                ctl.alu_y  = ALUY_IMM;
                ctl.alu_op = ALU_ADD;
            end
            S_WB_R: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            S_WB_I: ctl.reg_write = 1'b1;
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_x    = ALUX_RS;
                ctl.alu_y    = ALUY_RT;
                ctl.alu_op   = ALU_SUB;
                ctl.pc_src   = PCSRC_ALUOUT;
                ctl.pc_write = bus.zero;
            end
            S_JUMP: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PCSRC_JUMP;
            end
            S_TRAP:  ctl.illegal_inst = 1'b1;
            default: ctl = '0;
        endcase
    end

    assign bus.memRead     = ctl.mem_read;
    assign bus.memWrite    = ctl.mem_write;
    assign bus.iOrD        = ctl.i_or_d;
    assign bus.irWrite     = ctl.ir_write;
    assign bus.pcWrite     = ctl.pc_write;
    assign bus.regWrite    = ctl.reg_write;
    assign bus.memToReg    = ctl.mem_to_reg;
    assign bus.regDst      = ctl.reg_dst;
    assign bus.pcSrc       = ctl.pc_src;
    assign bus.aluX        = ctl.alu_x;
    assign bus.aluY        = ctl.alu_y;
    assign bus.aluOp       = ctl.alu_op;
    assign bus.illegalInst = ctl.illegal_inst;
    assign bus.stateOut    = state_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench: an instruction-level model expands each
// instruction into its expected per-cycle state/output sequence.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_instr = 0;
    int   cyc = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mrdy;
        logic        z;
        logic [3:0]  st;
        logic [19:0] outs;
    } cyc_t;

    cyc_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected output vector: {memRead,memWrite,iOrD,irWrite,pcWrite,regWrite,
    // memToReg,regDst,pcSrc,aluX,aluY,aluOp,illegalInst}
    function automatic logic [19:0] ov(input bit mrd, input bit mwr, input bit iod,
                                       input bit irw, input bit pcw, input bit rgw,
                                       input bit m2r, input bit rdst, input int pcs,
                                       input int ax, input int ay, input int aop,
                                       input bit ill);
        return {mrd, mwr, iod, irw, pcw, rgw, m2r, rdst,
                2'(pcs), 2'(ax), 3'(ay), 4'(aop), ill};
    endfunction

    function automatic void ref_funct(input logic [5:0] fn, output int aop,
                                      output bit sh, output bit ok);
        ok = 1'b1; sh = 1'b0; aop = 0;
        case (fn)
            6'h20: aop = 0;
            6'h22: aop = 1;
            6'h24: aop = 2;
            6'h25: aop = 3;
            6'h2A: aop = 4;
            6'h00: begin aop = 5; sh = 1'b1; end
            6'h02: begin aop = 6; sh = 1'b1; end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic mr, input logic z, input state_t st,
                        input logic [19:0] o);
        cyc_t c;
        c.r = r; c.op = op; c.fn = fn; c.mrdy = mr; c.z = z; c.st = st; c.outs = o;
        q.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its cycle sequence. rst_at >= 0 aborts a store
    // with a reset in that MEM_WR wait cycle; tl is the trap dwell before reset.
    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                               input int mw, input bit zb, input int rst_at, input int tl);
        int  aop;
        bit  sh, ok, trap;
        logic [19:0] zo;
        zo = ov(0,0,0,0,0,0,0,0, 0,0,0,0, 0);
        trap = 1'b0;
        for (int i = 0; i < fw; i++)
            push(0, op, fn, 0, rb(), S_FETCH, ov(1,0,0,0,0,0,0,0, 0,2,3,0, 0));
        push(0, op, fn, 1, rb(), S_FETCH, ov(1,0,0,1,1,0,0,0, 0,2,3,0, 0));
        push(0, op, fn, rb(), rb(), S_DECODE, ov(0,0,0,0,0,0,0,0, 0,2,2,0, 0));
        case (op)
            6'h00: begin
                ref_funct(fn, aop, sh, ok);
                if (!ok) trap = 1'b1;
                else begin
                    if (sh) push(0, op, fn, rb(), rb(), S_EXEC_SH, ov(0,0,0,0,0,0,0,0, 0,1,1,aop, 0));
                    else    push(0, op, fn, rb(), rb(), S_EXEC_R,  ov(0,0,0,0,0,0,0,0, 0,0,0,aop, 0));
                    push(0, op, fn, rb(), rb(), S_WB_R, ov(0,0,0,0,0,1,0,1, 0,0,0,0, 0));
                end
            end
            6'h08: begin
                push(0, op, fn, rb(), rb(), S_EXEC_I, ov(0,0,0,0,0,0,0,0, 0,0,2,0, 0));
                push(0, op, fn, rb(), rb(), S_WB_I,   ov(0,0,0,0,0,1,0,0, 0,0,0,0, 0));
            end
            6'h23: begin
                push(0, op, fn, rb(), rb(), S_MEM_ADDR, ov(0,0,0,0,0,0,0,0, 0,0,2,0, 0));
                for (int i = 0; i < mw; i++)
                    push(0, op, fn, 0, rb(), S_MEM_RD, ov(1,0,1,0,0,0,0,0, 0,0,0,0, 0));
                push(0, op, fn, 1, rb(), S_MEM_RD, ov(1,0,1,0,0,0,0,0, 0,0,0,0, 0));
                push(0, op, fn, rb(), rb(), S_WB_MEM, ov(0,0,0,0,0,1,1,0, 0,0,0,0, 0));
            end
            6'h2B: begin
                push(0, op, fn, rb(), rb(), S_MEM_ADDR, ov(0,0,0,0,0,0,0,0, 0,0,2,0, 0));
                for (int i = 0; i < mw; i++) begin
                    if (i == rst_at) begin
                        push(1, op, fn, 0, rb(), S_MEM_WR, ov(0,1,1,0,0,0,0,0, 0,0,0,0, 0));
                        push(0, op, fn, rb(), rb(), S_IDLE, zo);
                        return;
                    end
                    push(0, op, fn, 0, rb(), S_MEM_WR, ov(0,1,1,0,0,0,0,0, 0,0,0,0, 0));
                end
                push(0, op, fn, 1, rb(), S_MEM_WR, ov(0,1,1,0,0,0,0,0, 0,0,0,0, 0));
            end
            6'h04: push(0, op, fn, rb(), zb, S_BRANCH, ov(0,0,0,0,zb,0,0,0, 1,0,0,1, 0));
            6'h02: push(0, op, fn, rb(), rb(), S_JUMP, ov(0,0,0,0,1,0,0,0, 2,0,0,0, 0));
            default: trap = 1'b1;
        endcase
        if (trap) begin
            for (int i = 0; i < tl; i++)
                push(0, op, fn, rb(), rb(), S_TRAP, ov(0,0,0,0,0,0,0,0, 0,0,0,0, 1));
            push(1, op, fn, rb(), rb(), S_TRAP, ov(0,0,0,0,0,0,0,0, 0,0,0,0, 1));
            push(0, op, fn, rb(), rb(), S_IDLE, zo);
        end
    endtask

    task automatic drive_queue();
        cyc_t c;
        logic [19:0] got;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            rst          = c.r;
            bus.opcode   = c.op;
            bus.funct    = c.fn;
            bus.memReady = c.mrdy;
            bus.zero     = c.z;
            #1;
            got = {bus.memRead, bus.memWrite, bus.iOrD, bus.irWrite, bus.pcWrite,
                   bus.regWrite, bus.memToReg, bus.regDst, bus.pcSrc, bus.aluX,
                   bus.aluY, bus.aluOp, bus.illegalInst};
            check("state", 32'(bus.stateOut), 32'(c.st));
            check("outputs", 32'(got), 32'(c.outs));
            cyc++;
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw, input bit zb, input int rst_at, input int tl);
        model_instr(op, fn, fw, mw, zb, rst_at, tl);
        $display("instr %0d: op=%02h funct=%02h fetch_wait=%0d mem_wait=%0d zero=%0d rst_at=%0d cycles=%0d",
                 n_instr, op, fn, fw, mw, zb, rst_at, q.size());
        n_instr++;
        drive_queue();
    endtask

    logic [5:0] ops [6]    = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    logic [5:0] functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};

    initial begin
        logic [5:0] op, fn;
        bus.opcode = '0; bus.funct = '0; bus.memReady = 1'b1; bus.zero = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        push(0, 6'h00, 6'h20, 1, 0, S_IDLE, ov(0,0,0,0,0,0,0,0, 0,0,0,0, 0));
        drive_queue();

        run(6'h00, 6'h20, 0, 0, 0, -1, 0);   // add
        run(6'h23, 6'h00, 0, 2, 0, -1, 0);   // lw with 2 wait cycles
        run(6'h04, 6'h00, 0, 0, 1, -1, 0);   // beq taken
        run(6'h04, 6'h00, 0, 0, 0, -1, 0);   // beq not taken
        run(6'h00, 6'h00, 0, 0, 0, -1, 0);   // sll
        run(6'h00, 6'h02, 1, 0, 0, -1, 0);   // srl
        run(6'h02, 6'h00, 0, 0, 0, -1, 0);   // j
        run(6'h08, 6'h11, 2, 0, 0, -1, 0);   // addi
        run(6'h2B, 6'h00, 0, 1, 0, -1, 0);   // sw
        run(6'h00, 6'h2A, 0, 0, 0, -1, 0);   // slt
        run(6'h3F, 6'h00, 0, 0, 0, -1, 10);  // illegal opcode
        run(6'h00, 6'h3F, 0, 0, 0, -1, 2);   // illegal funct
        run(6'h2B, 6'h00, 1, 5, 0, 2, 0);    // reset mid-store

        for (int k = 0; k < 80; k++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 6)];
            run(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1,
                $urandom_range(1, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
